// File: rtl/countdown_counter_pkg.sv
// Shared types and defaults for the loadable countdown counter.
package countdown_counter_pkg;

  localparam int CNT_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_counter_if.sv
// Start-value load port: valid/ready handshake plus the value.
interface countdown_counter_if
  import countdown_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_val;

  modport master (
    output load_valid,
    output load_val,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_val,
    output load_ready
  );

endinterface

// File: rtl/countdown_counter_decrementor.sv
// Combinational minus-one, the mirror of the incrementor.
module decrementor #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] o
);

  assign o = inp - WIDTH'(1);

endmodule

// File: rtl/countdown_counter.sv
// Loadable down-counter with one-cycle done pulse and optional auto-reload.
module countdown_counter
  import countdown_counter_pkg::*;
#(
  parameter int WIDTH       = CNT_WIDTH_DEFAULT,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  countdown_counter_if.slave  load,
  input  logic                en,
  input  logic                abort,
  output logic [WIDTH-1:0]    count,
  output logic                busy,
  output logic                done
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_n;
  logic [WIDTH-1:0] dec;

  decrementor #(
    .WIDTH(WIDTH)
  ) u_dec (
    .inp(count),
    .o  (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
    end
  end

  // abort wins over both the decrement and the DONE exit
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    unique case (state)
      IDLE: begin
        if (load.load_valid) begin
          count_n  = load.load_val;
          reload_n = load.load_val;
          state_n  = (load.load_val != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (en) begin
          count_n = dec;
          if (count == WIDTH'(1)) state_n = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_n = IDLE;
        end else if (AUTO_RELOAD && reload != '0) begin
          count_n = reload;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign load.load_ready = (state == IDLE);
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_countdown_counter.sv
// Vector-table bench for countdown_counter, plain and auto-reload builds.
module tb_countdown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, en0, abort0, busy0, done0;
  logic       rst1, en1, abort1, busy1, done1;
  logic [3:0] count0, count1;

  countdown_counter_if #(.WIDTH(4)) if0 ();
  countdown_counter_if #(.WIDTH(4)) if1 ();

  countdown_counter #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clk  (clk),
    .rst  (rst0),
    .load (if0),
    .en   (en0),
    .abort(abort0),
    .count(count0),
    .busy (busy0),
    .done (done0)
  );

  countdown_counter #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk  (clk),
    .rst  (rst1),
    .load (if1),
    .en   (en1),
    .abort(abort1),
    .count(count1),
    .busy (busy1),
    .done (done1)
  );

  typedef struct {
    bit       sel;
    logic     rst;
    logic     valid;
    logic [3:0] val;
    logic     en;
    logic     abort;
    logic [3:0] ec;
    logic     eb;
    logic     ed;
    logic     er;
  } vec_t;

  typedef struct {
    int         idx;
    bit         sel;
    logic [3:0] ec;
    logic       eb;
    logic       ed;
    logic       er;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(bit s, logic r, logic v, int val,
                              logic e, logic a, int ec,
                              logic eb, logic ed, logic er);
    vec_t t;
    t.sel = s; t.rst = r; t.valid = v; t.val = 4'(val);
    t.en = e; t.abort = a; t.ec = 4'(ec);
    t.eb = eb; t.ed = ed; t.er = er;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL v%0d %s: got %0h, expected %0h", idx, name, act, req);
  endtask

  task automatic apply(int idx, vec_t t);
    exp_t e;
    rst0 = 1'b0; en0 = 1'b0; abort0 = 1'b0; if0.load_valid = 1'b0;
    rst1 = 1'b0; en1 = 1'b0; abort1 = 1'b0; if1.load_valid = 1'b0;
    if (!t.sel) begin
      rst0 = t.rst; en0 = t.en; abort0 = t.abort;
      if0.load_valid = t.valid; if0.load_val = t.val;
    end else begin
      rst1 = t.rst; en1 = t.en; abort1 = t.abort;
      if1.load_valid = t.valid; if1.load_val = t.val;
    end
    e.idx = idx; e.sel = t.sel;
    e.ec = t.ec; e.eb = t.eb; e.ed = t.ed; e.er = t.er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!e.sel) begin
      chk("count", e.idx, count0, e.ec);
      chk("busy", e.idx, 4'(busy0), 4'(e.eb));
      chk("done", e.idx, 4'(done0), 4'(e.ed));
      chk("load_ready", e.idx, 4'(if0.load_ready), 4'(e.er));
    end else begin
      chk("count", e.idx, count1, e.ec);
      chk("busy", e.idx, 4'(busy1), 4'(e.eb));
      chk("done", e.idx, 4'(done1), 4'(e.ed));
      chk("load_ready", e.idx, 4'(if1.load_ready), 4'(e.er));
    end
  endtask

  initial begin
    rst0 = 1'b1; en0 = 1'b0; abort0 = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; abort1 = 1'b0;
    if0.load_valid = 1'b0; if0.load_val = '0;
    if1.load_valid = 1'b0; if1.load_val = '0;

    //           s r v val e a  cnt b d rdy
    // reset state, plain build
    tbl.push_back(mk(0,1,0,0, 0,0, 0, 0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0, 0, 0,0,1));
    // load 5, en held: 5..0, done on 0, then idle
    tbl.push_back(mk(0,0,1,5, 1,0, 5, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 4, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 3, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 2, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 1, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 0, 1,1,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 0, 0,0,1));
    // load 3, en toggling
    tbl.push_back(mk(0,0,1,3, 0,0, 3, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 2, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 2, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 1, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 1, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,0, 0, 1,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 0, 0,0,1));
    // load 0 -> DONE once
    tbl.push_back(mk(0,0,1,0, 0,0, 0, 1,1,0));
    tbl.push_back(mk(0,0,0,0, 0,0, 0, 0,0,1));
    // load_valid held during RUN/DONE, accepted only back in IDLE
    tbl.push_back(mk(0,0,1,2, 0,0, 2, 1,0,0));
    tbl.push_back(mk(0,0,1,9, 0,0, 2, 1,0,0));
    tbl.push_back(mk(0,0,1,9, 1,0, 1, 1,0,0));
    tbl.push_back(mk(0,0,1,9, 1,0, 0, 1,1,0));
    tbl.push_back(mk(0,0,1,9, 1,0, 0, 0,0,1));
    tbl.push_back(mk(0,0,1,9, 0,0, 9, 1,0,0));
    // abort freezes count
    tbl.push_back(mk(0,0,0,0, 1,1, 9, 0,0,1));
    // abort on the 1->0 step: no done, count stays 1
    tbl.push_back(mk(0,0,1,1, 0,0, 1, 1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1, 1, 0,0,1));
    tbl.push_back(mk(0,0,0,0, 1,0, 1, 0,0,1));
    // reset mid-run at count 7
    tbl.push_back(mk(0,0,1,7, 0,0, 7, 1,0,0));
    tbl.push_back(mk(0,1,0,0, 1,0, 0, 0,0,1));
    tbl.push_back(mk(0,1,0,0, 1,0, 0, 0,0,1));
    tbl.push_back(mk(0,0,0,0, 1,0, 0, 0,0,1));
    // auto-reload build: reset, load 0 never repeats
    tbl.push_back(mk(1,1,0,0, 0,0, 0, 0,0,1));
    tbl.push_back(mk(1,0,1,0, 0,0, 0, 1,1,0));
    tbl.push_back(mk(1,0,0,0, 0,0, 0, 0,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0, 0, 0,0,1));
    // load 2: 2,1,0,2,1,0,2,1 then abort at 1
    tbl.push_back(mk(1,0,1,2, 1,0, 2, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0, 1, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0, 0, 1,1,0));
    tbl.push_back(mk(1,0,0,0, 1,0, 2, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0, 1, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0, 0, 1,1,0));
    tbl.push_back(mk(1,0,0,0, 1,0, 2, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0, 1, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 1,1, 1, 0,0,1));
    tbl.push_back(mk(1,0,0,0, 1,0, 1, 0,0,1));
    // abort during DONE suppresses the reload
    tbl.push_back(mk(1,0,1,1, 1,0, 1, 1,0,0));
    tbl.push_back(mk(1,0,0,0, 1,0, 0, 1,1,0));
    tbl.push_back(mk(1,0,0,0, 1,1, 0, 0,0,1));
    tbl.push_back(mk(1,0,0,0, 1,0, 0, 0,0,1));

    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    // randomized countdown with en held: done after exactly N decrements
    for (int k = 0; k < 4; k++) begin
      int n;
      int cyc;
      n = $urandom_range(15, 2);
      apply(1000 + k, mk(0,0,1,n, 1,0, n, 1,0,0));
      cyc = 0;
      en0 = 1'b1;
      while (done0 !== 1'b1 && cyc < 40) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("rand_latency", 1000 + k, 4'(cyc), 4'(n));
      chk("rand_count0", 1000 + k, count0, 4'd0);
      @(posedge clk);
      #1;
      chk("rand_ready", 1000 + k, 4'(if0.load_ready), 4'd1);
    end

    if (sb.size() != 0) begin
      total++;
      $display("FAIL scoreboard: %0d left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
